fetch_byte_queue: RTL and testbench
===================================

FETCH_BYTE_QUEUE -- requirements
Module: fetch_byte_queue

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 64, meaning bytes per icache line; only the value 64 is supported.
REQ-002 SHALL have parameter NUM_SLOTS, default 2, meaning line slots in the byte buffer (128-byte circular store); only the value 2 is supported.
REQ-003 SHALL have parameter WIN_BYTES, default 16, meaning bytes presented to decode per cycle; only the value 16 is supported.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port redirect, input, 1 bit: flush the queue and restart fetch at redirect_pc.
REQ-007 SHALL have port redirect_pc, input, 32 bits: new fetch PC (any byte alignment).
REQ-008 SHALL have port fetch_req, output, 1 bit: request to the icache for line fetch_addr.
REQ-009 SHALL have port fetch_addr, output, 32 bits: line-aligned VA of the next line wanted; bits [5:0] are always 0.
REQ-010 SHALL have port line_valid, input, 1 bit: the icache presents a hit line.
REQ-011 SHALL have port line_addr, input, 32 bits: VA of the presented line; bits [5:0] are ignored.
REQ-012 SHALL have port line_data, input, 512 bits: line bytes, byte k at bits [8k+7:8k].
REQ-013 SHALL have port line_ready, output, 1 bit: a free slot exists.
REQ-014 SHALL have port win_valid, output, 1 bit: at least 16 valid bytes are queued.
REQ-015 SHALL have port win_bytes, output, 128 bits: the 16 bytes from head, byte i at bits [8i+7:8i].
REQ-016 SHALL have port win_pc, output, 32 bits: VA of win_bytes byte 0.
REQ-017 SHALL have port consume, input, 1 bit: decode retires bytes this cycle.
REQ-018 SHALL have port consume_len, input, 5 bits: bytes retired; legal range 1..16.

Function
REQ-019 SHALL hold state: 128-byte buffer, head index (7 bits, wraps modulo 128), count (8 bits, 0..128), slot_full[1:0], tail_slot (1 bit), started flag, win_pc, fetch_addr, first_line flag.
REQ-020 SHALL accept a line when line_valid, line_ready, !redirect and line_addr[31:6]==fetch_addr[31:6] all hold; a line_valid with mismatched address SHALL be dropped with no state change (stale line).
REQ-021 On accept SHALL write line_data into slot tail_slot, set slot_full[tail_slot], toggle tail_slot, and add 64 to fetch_addr (wrapping modulo 2^32).
REQ-022 On accept with first_line=0 SHALL add 64 to count; with first_line=1 SHALL set head to tail_slot*64 + win_pc[5:0], set count to 64 - win_pc[5:0], and clear first_line.
REQ-023 SHALL drive line_ready = started & !(slot_full[0] & slot_full[1]), and fetch_req = line_ready & !redirect.
REQ-024 SHALL drive win_valid = (count >= 16); win_bytes byte i = buffer[(head+i) mod 128], combinational from state.
REQ-025 A consume SHALL take effect only when consume & win_valid & 1<=consume_len<=16; otherwise it is ignored.
REQ-026 An effective consume SHALL add consume_len to head (mod 128) and to win_pc (mod 2^32), and subtract consume_len from count.
REQ-027 SHALL clear slot_full[s] in the cycle head advances out of slot s (old head[6]==s and new head[6]!=s); the freed slot is writable from the next cycle.
REQ-028 A simultaneous accept and consume SHALL both apply; count_next = count + added - consume_len.
REQ-029 Redirect SHALL take priority over accept and consume in the same cycle: count=0, slot_full=0, tail_slot=0, head=0, first_line=1, started=1, win_pc=redirect_pc, fetch_addr={redirect_pc[31:6],6'b0}.
REQ-030 count SHALL never exceed 128 nor underflow; with 128 bytes queued, line_ready=0.
REQ-031 A 16-byte window whose bytes straddle slot 1 and slot 0 (head > 112) SHALL be presented contiguously via the wrap.

Reset
REQ-032 While rst_n=0, regardless of clk: count=0, head=0, slot_full=0, tail_slot=0, started=0, first_line=1, win_pc=0, fetch_addr=0; so fetch_req=0, line_ready=0, win_valid=0.
REQ-033 After reset the block SHALL issue no fetch_req until the first redirect.
REQ-034 Reset asserted mid-operation SHALL discard all queued bytes; a line_valid in that cycle is ignored.

Verification
REQ-035 Redirect to 0x1000_0005, supply line 0x1000_0000 -> next cycle count=59, win_valid=1, win_pc=0x1000_0005, win_bytes byte0=line byte 5, fetch_addr=0x1000_0040.
REQ-036 Fill both slots from redirect 0x2000 -> line_ready=0, fetch_req=0; consume 16 four times -> slot 0 freed, line_ready=1 in the following cycle.
REQ-037 Head at index 120 with count 20 -> win_bytes bytes 0..7 from buffer 120..127 and bytes 8..15 from 0..7.
REQ-038 Same-cycle accept (+64) and consume 7 with count 20 -> count=77, win_pc advanced by 7.
REQ-039 Redirect coincident with line_valid and consume -> line and consume ignored, count=0, fetch_addr=new line; a later line_valid at the old address -> dropped.
REQ-040 consume_len=0, consume_len=17, or consume with count=10 -> no state change; rst_n low mid-fill -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fetch_byte_queue.sv
// Fetch byte queue: buffers two icache lines in a 128-byte circular store and
// presents a 16-byte decode window starting at an arbitrary byte PC.
module fetch_byte_queue #(
    parameter int LINE_BYTES = 64,
    parameter int NUM_SLOTS  = 2,
    parameter int WIN_BYTES  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         fetch_req,
    output logic [31:0]  fetch_addr,
    input  logic         line_valid,
    input  logic [31:0]  line_addr,
    input  logic [511:0] line_data,
    output logic         line_ready,
    output logic         win_valid,
    output logic [127:0] win_bytes,
    output logic [31:0]  win_pc,
    input  logic         consume,
    input  logic [4:0]   consume_len
);

    localparam int BUF_BYTES = LINE_BYTES * NUM_SLOTS;

    logic [7:0]  buf_q [BUF_BYTES];
    logic [6:0]  head_q, head_d;
    logic [7:0]  count_q, count_d;
    logic [1:0]  slot_full_q, slot_full_d;
    logic        tail_slot_q, tail_slot_d;
    logic        started_q, started_d;
    logic        first_line_q, first_line_d;
    logic [31:0] win_pc_q, win_pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;

    logic        accept;
    logic        cons_ok;
    logic [6:0]  head_adv;
    logic [7:0]  add_bytes;
    logic [7:0]  sub_bytes;
    logic        unused_line_off;

    assign unused_line_off = ^line_addr[5:0];

    assign line_ready = started_q & ~(slot_full_q[0] & slot_full_q[1]);
    assign fetch_req  = line_ready & ~redirect;
    assign win_valid  = (count_q >= 8'(WIN_BYTES));
    assign win_pc     = win_pc_q;
    assign fetch_addr = fetch_addr_q;

    // Stale lines (address not the one we asked for) are silently dropped.
    assign accept  = line_valid & line_ready & ~redirect &
                     (line_addr[31:6] == fetch_addr_q[31:6]);
    assign cons_ok = consume & win_valid & (consume_len != 5'd0) &
                     (consume_len <= 5'(WIN_BYTES));

    assign head_adv  = head_q + (cons_ok ? {2'b00, consume_len} : 7'd0);
    assign sub_bytes = cons_ok ? {3'b000, consume_len} : 8'd0;
    assign add_bytes = !accept      ? 8'd0 :
                       first_line_q ? (8'(LINE_BYTES) - {2'b00, win_pc_q[5:0]}) :
                                      8'(LINE_BYTES);

    always_comb begin
        head_d       = head_q;
        count_d      = count_q;
        slot_full_d  = slot_full_q;
        tail_slot_d  = tail_slot_q;
        started_d    = started_q;
        first_line_d = first_line_q;
        win_pc_d     = win_pc_q;
        fetch_addr_d = fetch_addr_q;
        if (redirect) begin
            head_d       = 7'd0;
            count_d      = 8'd0;
            slot_full_d  = 2'b00;
            tail_slot_d  = 1'b0;
            started_d    = 1'b1;
            first_line_d = 1'b1;
            win_pc_d     = redirect_pc;
            fetch_addr_d = {redirect_pc[31:6], 6'b0};
        end else begin
            count_d = count_q + add_bytes - sub_bytes;
            if (cons_ok) begin
                head_d   = head_adv;
                win_pc_d = win_pc_q + {27'd0, consume_len};
                // Leaving a slot frees it for the next incoming line.
                if (head_adv[6] != head_q[6])
                    slot_full_d[head_q[6]] = 1'b0;
            end
            if (accept) begin
                slot_full_d[tail_slot_q] = 1'b1;
                tail_slot_d  = ~tail_slot_q;
                fetch_addr_d = fetch_addr_q + 32'(LINE_BYTES);
                if (first_line_q) begin
                    head_d       = {tail_slot_q, win_pc_q[5:0]};
                    first_line_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= 7'd0;
            count_q      <= 8'd0;
            slot_full_q  <= 2'b00;
            tail_slot_q  <= 1'b0;
            started_q    <= 1'b0;
            first_line_q <= 1'b1;
            win_pc_q     <= 32'd0;
            fetch_addr_q <= 32'd0;
        end else begin
            head_q       <= head_d;
            count_q      <= count_d;
            slot_full_q  <= slot_full_d;
            tail_slot_q  <= tail_slot_d;
            started_q    <= started_d;
            first_line_q <= first_line_d;
            win_pc_q     <= win_pc_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    // Byte store needs no reset; validity is tracked by count/slot_full.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < LINE_BYTES; k++)
                buf_q[{tail_slot_q, k[5:0]}] <= line_data[8*k +: 8];
        end
    end

    for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_win
        assign win_bytes[8*gi +: 8] = buf_q[head_q + 7'(gi)];
    end

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed bench for fetch_byte_queue: vector table plus hand-written reset and
// redirect-gating sequences. Line bytes encode their own VA so windows are predictable.
module tb_fetch_byte_queue;

    logic         clk;
    logic         rst_n;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic         line_valid;
    logic [31:0]  line_addr;
    logic [511:0] line_data;
    logic         line_ready;
    logic         win_valid;
    logic [127:0] win_bytes;
    logic [31:0]  win_pc;
    logic         consume;
    logic [4:0]   consume_len;

    int checks;
    int errors;

    fetch_byte_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .line_valid  (line_valid),
        .line_addr   (line_addr),
        .line_data   (line_data),
        .line_ready  (line_ready),
        .win_valid   (win_valid),
        .win_bytes   (win_bytes),
        .win_pc      (win_pc),
        .consume     (consume),
        .consume_len (consume_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        lv;
        logic [31:0] la;
        logic        cons;
        logic [4:0]  clen;
        logic        e_ready;
        logic        e_wv;
        logic [31:0] e_pc;
        logic [31:0] e_fa;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic [31:0] rpc, logic lv, logic [31:0] la,
                                logic c, logic [4:0] cl, logic er, logic ew,
                                logic [31:0] ep, logic [31:0] ef);
        vec_t v;
        v.redir = r; v.rpc = rpc; v.lv = lv; v.la = la; v.cons = c; v.clen = cl;
        v.e_ready = er; v.e_wv = ew; v.e_pc = ep; v.e_fa = ef;
        return v;
    endfunction

    function automatic logic [7:0] vbyte(logic [31:0] va);
        return va[7:0] ^ va[15:8];
    endfunction

    function automatic logic [511:0] line_for(logic [31:0] a);
        logic [511:0] r;
        for (int k = 0; k < 64; k++)
            r[8*k +: 8] = vbyte({a[31:6], 6'b0} + 32'(k));
        return r;
    endfunction

    function automatic logic [127:0] win_model(logic [31:0] pc);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = vbyte(pc + 32'(i));
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        line_valid  = 1'b0;
        line_addr   = 32'd0;
        line_data   = '0;
        consume     = 1'b0;
        consume_len = 5'd0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_fetch_req"},  {127'd0, fetch_req},  128'd0);
        chk({tag, "_line_ready"}, {127'd0, line_ready}, 128'd0);
        chk({tag, "_win_valid"},  {127'd0, win_valid},  128'd0);
        chk({tag, "_win_pc"},     {96'd0, win_pc},      128'd0);
        chk({tag, "_fetch_addr"}, {96'd0, fetch_addr},  128'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst_n = 1'b0;

        //           redir rpc            lv la            c  len  rdy wv pc             fa
        vq.push_back(mk(0, 32'h0,         1, 32'h0,        0, 0,   0, 0, 32'h0,        32'h0));
        vq.push_back(mk(1, 32'h10000005,  0, 32'h0,        0, 0,   1, 0, 32'h10000005, 32'h10000000));
        vq.push_back(mk(0, 32'h0,         1, 32'h10000000, 0, 0,   1, 1, 32'h10000005, 32'h10000040));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h10000015, 32'h10000040));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h10000025, 32'h10000040));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 0, 32'h10000035, 32'h10000040));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 5,   1, 0, 32'h10000035, 32'h10000040));
        vq.push_back(mk(0, 32'h0,         1, 32'h10000040, 0, 0,   0, 1, 32'h10000035, 32'h10000080));
        vq.push_back(mk(0, 32'h0,         1, 32'h10000080, 0, 0,   0, 1, 32'h10000035, 32'h10000080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 11,  1, 1, 32'h10000040, 32'h10000080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 0,   1, 1, 32'h10000040, 32'h10000080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 17,  1, 1, 32'h10000040, 32'h10000080));
        vq.push_back(mk(0, 32'h0,         1, 32'h50000000, 0, 0,   1, 1, 32'h10000040, 32'h10000080));
        vq.push_back(mk(0, 32'h0,         1, 32'h10000080, 0, 0,   0, 1, 32'h10000040, 32'h100000c0));
        vq.push_back(mk(1, 32'h2000,      0, 32'h0,        0, 0,   1, 0, 32'h2000,     32'h2000));
        vq.push_back(mk(0, 32'h0,         1, 32'h2000,     0, 0,   1, 1, 32'h2000,     32'h2040));
        vq.push_back(mk(0, 32'h0,         1, 32'h2040,     0, 0,   0, 1, 32'h2000,     32'h2080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  0, 1, 32'h2010,     32'h2080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  0, 1, 32'h2020,     32'h2080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  0, 1, 32'h2030,     32'h2080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h2040,     32'h2080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h2050,     32'h2080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h2060,     32'h2080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h2070,     32'h2080));
        vq.push_back(mk(0, 32'h0,         1, 32'h2080,     0, 0,   0, 1, 32'h2070,     32'h20c0));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 8,   0, 1, 32'h2078,     32'h20c0));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 10,  1, 1, 32'h2082,     32'h20c0));
        vq.push_back(mk(1, 32'h3000002C,  0, 32'h0,        0, 0,   1, 0, 32'h3000002C, 32'h30000000));
        vq.push_back(mk(0, 32'h0,         1, 32'h30000000, 0, 0,   1, 1, 32'h3000002C, 32'h30000040));
        vq.push_back(mk(0, 32'h0,         1, 32'h30000040, 1, 7,   0, 1, 32'h30000033, 32'h30000080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h30000043, 32'h30000080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h30000053, 32'h30000080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h30000063, 32'h30000080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 13,  1, 1, 32'h30000070, 32'h30000080));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 1,   1, 0, 32'h30000071, 32'h30000080));
        vq.push_back(mk(1, 32'h40000010,  1, 32'h30000080, 1, 5,   1, 0, 32'h40000010, 32'h40000000));
        vq.push_back(mk(0, 32'h0,         1, 32'h30000080, 0, 0,   1, 0, 32'h40000010, 32'h40000000));
        vq.push_back(mk(0, 32'h0,         1, 32'h40000000, 0, 0,   1, 1, 32'h40000010, 32'h40000040));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h40000020, 32'h40000040));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 1, 32'h40000030, 32'h40000040));
        vq.push_back(mk(0, 32'h0,         0, 32'h0,        1, 16,  1, 0, 32'h40000040, 32'h40000040));

        #3;
        check_reset_outputs("por");
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[n]) begin
            redirect    = vq[n].redir;
            redirect_pc = vq[n].rpc;
            line_valid  = vq[n].lv;
            line_addr   = vq[n].la;
            line_data   = line_for(vq[n].la);
            consume     = vq[n].cons;
            consume_len = vq[n].clen;
            @(posedge clk);
            #1;
            idle_inputs();
            #1;
            $display("vec %0d redir=%0b lv=%0b la=%08h cons=%0b len=%0d -> rdy=%0b req=%0b wv=%0b pc=%08h fa=%08h",
                     n, vq[n].redir, vq[n].lv, vq[n].la, vq[n].cons, vq[n].clen,
                     line_ready, fetch_req, win_valid, win_pc, fetch_addr);
            chk($sformatf("v%0d_line_ready", n), {127'd0, line_ready}, {127'd0, vq[n].e_ready});
            chk($sformatf("v%0d_fetch_req", n),  {127'd0, fetch_req},  {127'd0, vq[n].e_ready});
            chk($sformatf("v%0d_win_valid", n),  {127'd0, win_valid},  {127'd0, vq[n].e_wv});
            chk($sformatf("v%0d_win_pc", n),     {96'd0, win_pc},      {96'd0, vq[n].e_pc});
            chk($sformatf("v%0d_fetch_addr", n), {96'd0, fetch_addr},  {96'd0, vq[n].e_fa});
            if (vq[n].e_wv)
                chk($sformatf("v%0d_win_bytes", n), win_bytes, win_model(vq[n].e_pc));
        end

        // Queue a line, then pull reset mid-cycle while another line is offered.
        line_valid = 1'b1;
        line_addr  = 32'h40000040;
        line_data  = line_for(32'h40000040);
        @(posedge clk);
        #1;
        $display("seq fill 40000040 -> wv=%0b pc=%08h fa=%08h", win_valid, win_pc, fetch_addr);
        chk("fill_win_valid", {127'd0, win_valid}, {127'd0, 1'b1});
        chk("fill_win_bytes", win_bytes, win_model(32'h40000040));
        line_addr = 32'h40000080;
        line_data = line_for(32'h40000080);
        #2 rst_n = 1'b0;
        #1;
        $display("seq async reset -> rdy=%0b req=%0b wv=%0b pc=%08h fa=%08h",
                 line_ready, fetch_req, win_valid, win_pc, fetch_addr);
        check_reset_outputs("arst");
        @(posedge clk);
        #1;
        check_reset_outputs("arst_edge");
        #2 rst_n = 1'b1;
        line_addr = 32'h0;
        line_data = line_for(32'h0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            $display("seq post-reset cycle %0d -> rdy=%0b req=%0b wv=%0b", c, line_ready, fetch_req, win_valid);
            check_reset_outputs($sformatf("noreq%0d", c));
        end

        // Redirect gates fetch_req combinationally even while a slot is free.
        idle_inputs();
        redirect    = 1'b1;
        redirect_pc = 32'h00000077;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        #1;
        chk("redir_ready", {127'd0, line_ready}, {127'd0, 1'b1});
        chk("redir_req",   {127'd0, fetch_req},  {127'd0, 1'b1});
        redirect = 1'b1;
        #1;
        $display("seq redirect held -> rdy=%0b req=%0b", line_ready, fetch_req);
        chk("redir_gate_req",   {127'd0, fetch_req},  128'd0);
        chk("redir_gate_ready", {127'd0, line_ready}, {127'd0, 1'b1});
        redirect = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
